cpu_trace_arbiter: RTL and testbench

Shares the single-character input port of the cpu_checker trace parser between N_SRC independent trace sources. Each source emits trace messages one character per cycle, for example "^242@00003f04: $31 <= 12345678#". The arbiter grants the checker to exactly one source per whole message, from '^' to '#'. It uses round-robin between sources, discards inter-message junk, and forces a terminating '#' if the granted source stalls too long. It sits directly in front of cpu_checker.char.

---
 rtl/cpu_trace_pkg.sv | 21 ++
 rtl/cpu_trace_if.sv | 15 +
 rtl/cpu_trace_arbiter_rr_picker.sv | 28 ++
 rtl/cpu_trace_arbiter.sv | 135 +++++++++++++
 tb/tb_cpu_trace_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: constants shared by the trace arbiter, cpu_checker and benches.
//   CH_*      : trace protocol characters ('^' opens a message, '#' closes it)
//   ST_*      : arbiter state encoding
//   sat_inc16 : saturating increment for the 16-bit message counters
package cpu_trace_pkg;

   localparam logic [7:0] CH_CARET = 8'h5E;
   localparam logic [7:0] CH_HASH  = 8'h23;
   localparam logic [7:0] CH_IDLE  = 8'h00;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_ABORT = 2'd2;

   typedef logic [7:0] trace_char_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/cpu_trace_if.sv
// cpu_trace_if: per-source character handshake bundle.
//   src_valid[i]          : source i presents a character
//   src_char[8i+7:8i]     : character of source i
//   src_ready[i]          : character of source i consumed this cycle
//   master modport = trace sources, slave modport = arbiter
interface cpu_trace_if #(
   parameter int N_SRC = 2
);
   logic [N_SRC-1:0]   src_valid;
   logic [8*N_SRC-1:0] src_char;
   logic [N_SRC-1:0]   src_ready;

   modport master (output src_valid, output src_char, input src_ready);
   modport slave  (input src_valid, input src_char, output src_ready);
endinterface

// File: rtl/cpu_trace_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker.
//   req         : request vector
//   ptr         : index with highest priority (must be < N)
//   grant_valid : at least one request is set
//   grant_idx   : first set request at or after ptr, ascending mod N
module rr_picker #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx
);

   // Walk offsets from farthest to nearest so the nearest request wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            grant_valid = 1'b1;
            grant_idx   = W'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/cpu_trace_arbiter.sv
// cpu_trace_arbiter: shares the cpu_checker character input between N_SRC
// trace sources, granting one whole '^'..'#' message at a time.
//   clk, reset : clock, synchronous active-low reset
//   src        : per-source valid/char/ready handshake (slave side)
//   out_char   : registered character to cpu_checker (00 when idle)
//   out_valid  : out_char carries a forwarded or injected character
//   out_src    : source of the current/last grant
//   abort      : one-cycle pulse with an injected '#' after a stall timeout
//   msg_done   : messages closed by the source's own '#', saturating
//   msg_abort  : timeout aborts, saturating
module cpu_trace_arbiter
   import cpu_trace_pkg::*;
#(
   parameter int N_SRC   = 2,
   parameter int TIMEOUT = 16,
   parameter int SRC_W   = 1
) (
   input  logic             clk,
   input  logic             reset,
   cpu_trace_if.slave       src,
   output logic [7:0]       out_char,
   output logic             out_valid,
   output logic [SRC_W-1:0] out_src,
   output logic             abort,
   output logic [15:0]      msg_done,
   output logic [15:0]      msg_abort
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [1:0]             state;
   logic [SRC_W-1:0]       rr_ptr;
   logic [CNT_W-1:0]       stall_cnt;

   logic [N_SRC-1:0][7:0]  chars;
   logic [N_SRC-1:0]       caret_req;
   logic [N_SRC-1:0]       ready;
   logic                   pick_vld;
   logic [SRC_W-1:0]       pick_idx;
   logic                   g_valid;
   trace_char_t            g_char;
   logic [SRC_W-1:0]       nxt_ptr;

   assign chars = src.src_char;

   always_comb begin
      for (int i = 0; i < N_SRC; i++)
         caret_req[i] = src.src_valid[i] && (chars[i] == CH_CARET);
   end

   rr_picker #(.N(N_SRC), .W(SRC_W)) u_pick (
      .req         (caret_req),
      .ptr         (rr_ptr),
      .grant_valid (pick_vld),
      .grant_idx   (pick_idx)
   );

   // out_src doubles as the granted source index while in GRANT/ABORT.
   assign g_valid = src.src_valid[out_src];
   assign g_char  = chars[out_src];
   // Just-served source drops to lowest priority.
   assign nxt_ptr = (int'(out_src) == N_SRC - 1) ? '0 : out_src + 1'b1;

   // Idle: drain junk from everyone, hold losing '^' sources until their turn.
   always_comb begin
      ready = '0;
      case (state)
         ST_IDLE: begin
            for (int i = 0; i < N_SRC; i++)
               ready[i] = src.src_valid[i] && (chars[i] != CH_CARET);
            if (pick_vld) ready[pick_idx] = 1'b1;
         end
         ST_GRANT: ready[out_src] = 1'b1;
         default:  ready = '0;
      endcase
   end

   assign src.src_ready = ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         out_char  <= CH_IDLE;
         out_valid <= 1'b0;
         out_src   <= '0;
         abort     <= 1'b0;
         msg_done  <= '0;
         msg_abort <= '0;
         rr_ptr    <= '0;
         stall_cnt <= '0;
      end else begin
         out_char  <= CH_IDLE;
         out_valid <= 1'b0;
         abort     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  out_char  <= CH_CARET;
                  out_valid <= 1'b1;
                  out_src   <= pick_idx;
                  stall_cnt <= '0;
                  state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // A character on the would-be timeout cycle still wins.
               if (g_valid) begin
                  out_char  <= g_char;
                  out_valid <= 1'b1;
                  stall_cnt <= '0;
                  if (g_char == CH_HASH) begin
                     msg_done <= sat_inc16(msg_done);
                     rr_ptr   <= nxt_ptr;
                     state    <= ST_IDLE;
                  end
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
                  if (stall_cnt == CNT_W'(TIMEOUT - 1)) state <= ST_ABORT;
               end
            end
            ST_ABORT: begin
               out_char  <= CH_HASH;
               out_valid <= 1'b1;
               abort     <= 1'b1;
               msg_abort <= sat_inc16(msg_abort);
               rr_ptr    <= nxt_ptr;
               stall_cnt <= '0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_trace_arbiter.sv
// tb_cpu_trace_arbiter: randomized + directed bench with a message-level
// reference model. The driver decides per cycle which source characters the
// arbiter must take and pushes the expected output characters into a
// scoreboard; an independent monitor pops and compares whenever out_valid.
module tb_cpu_trace_arbiter;
   import cpu_trace_pkg::*;

   localparam int N  = 3;
   localparam int TO = 16;
   localparam int W  = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   out_char;
   logic         out_valid;
   logic [W-1:0] out_src;
   logic         abort;
   logic [15:0]  msg_done, msg_abort;

   always #5 clk = ~clk;

   cpu_trace_if #(.N_SRC(N)) tif ();

   cpu_trace_arbiter #(.N_SRC(N), .TIMEOUT(TO), .SRC_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .src       (tif),
      .out_char  (out_char),
      .out_valid (out_valid),
      .out_src   (out_src),
      .abort     (abort),
      .msg_done  (msg_done),
      .msg_abort (msg_abort)
   );

   typedef struct {
      logic [7:0] ch;
      int         src;
      bit         ab;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_pass = 0;
   bit   mon_en = 1'b0;

   // Source streams: >=0 is a character, <0 is a stall of that many cycles.
   int   srcq[N][$];
   int   hold[N];
   int   vprob = 100;

   // Reference model state: who owns the checker, pending abort, priority.
   int   owner = -1;
   bit   aborting = 1'b0;
   int   stalled = 0;
   int   next_first = 0;
   int   m_done = 0, m_abort = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("out_valid_unexpected", {31'b0, out_valid}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_char", {24'b0, out_char}, {24'b0, e.ch});
               check("out_src", {30'b0, out_src}, e.src);
               check("abort_flag", {31'b0, abort}, {31'b0, e.ab});
            end
         end else begin
            check("idle_out", {23'b0, out_char, abort}, 32'd0);
         end
      end
   end

   task automatic load_str(input int s, input string str);
      for (int i = 0; i < str.len(); i++) srcq[s].push_back(int'(str[i]));
   endtask

   task automatic load_random_msg(input int s);
      int j, n;
      j = $urandom_range(3);
      for (int i = 0; i < j; i++) begin
         int ch;
         ch = $urandom_range(32, 126);
         if (ch == int'(CH_CARET)) ch = int'("x");
         srcq[s].push_back(ch);
      end
      srcq[s].push_back(int'(CH_CARET));
      n = $urandom_range(4, 30);
      for (int i = 0; i < n; i++) begin
         int ch;
         if ($urandom_range(99) < 5) srcq[s].push_back(-int'($urandom_range(1, 20)));
         ch = $urandom_range(32, 126);
         if (ch == int'(CH_HASH)) ch = int'("z");
         srcq[s].push_back(ch);
      end
      srcq[s].push_back(int'(CH_HASH));
   endtask

   // One clock of stimulus plus the model's verdict for that cycle.
   task automatic step();
      logic [N-1:0]   v, rdy;
      logic [7:0]     c [N];
      logic [8*N-1:0] cv;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b0;
         c[i] = 8'h00;
         if (hold[i] > 0) hold[i]--;
         else if (srcq[i].size() > 0) begin
            if (srcq[i][0] < 0) begin
               hold[i] = -srcq[i][0] - 1;
               void'(srcq[i].pop_front());
            end else if ($urandom_range(99) < vprob) begin
               v[i] = 1'b1;
               c[i] = 8'(srcq[i][0]);
            end
         end
         cv[8*i +: 8] = c[i];
      end
      tif.src_valid = v;
      tif.src_char  = cv;

      rdy = '0;
      if (aborting) begin
         sb.push_back('{CH_HASH, owner, 1'b1});
         m_abort++;
         next_first = (owner + 1) % N;
         owner = -1;
         aborting = 1'b0;
      end else if (owner < 0) begin
         for (int i = 0; i < N; i++) rdy[i] = v[i] && (c[i] != CH_CARET);
         for (int k = 0; k < N; k++) begin
            int s;
            s = (next_first + k) % N;
            if (owner < 0 && v[s] && c[s] == CH_CARET) begin
               owner = s;
               stalled = 0;
               rdy[s] = 1'b1;
               sb.push_back('{CH_CARET, s, 1'b0});
            end
         end
      end else begin
         rdy[owner] = 1'b1;
         if (v[owner]) begin
            sb.push_back('{c[owner], owner, 1'b0});
            stalled = 0;
            if (c[owner] == CH_HASH) begin
               m_done++;
               next_first = (owner + 1) % N;
               owner = -1;
            end
         end else begin
            stalled++;
            if (stalled == TO) aborting = 1'b1;
         end
      end
      #1;
      check("src_ready", {29'b0, tif.src_ready}, {29'b0, rdy});
      for (int i = 0; i < N; i++)
         if (rdy[i] && v[i]) void'(srcq[i].pop_front());
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_counters();
      run(TO + 4);
      @(negedge clk);
      check("msg_done", {16'b0, msg_done}, m_done);
      check("msg_abort", {16'b0, msg_abort}, m_abort);
   endtask

   initial begin
      tif.src_valid = '0;
      tif.src_char  = '0;
      for (int i = 0; i < N; i++) hold[i] = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_out_char", {24'b0, out_char}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_src", {30'b0, out_src}, 32'd0);
      check("rst_abort", {31'b0, abort}, 32'd0);
      check("rst_msg_done", {16'b0, msg_done}, 32'd0);
      check("rst_msg_abort", {16'b0, msg_abort}, 32'd0);
      check("rst_src_ready", {29'b0, tif.src_ready}, 32'd0);
      mon_en = 1'b1;

      // Simultaneous '^' after reset: src0 first, src1 held then granted.
      load_str(0, "^242@00003f04: $31 <= 12345678#");
      load_str(1, "^338@00003130: *00000088 <= ffffb528#");
      run(80);
      check_counters();

      // Junk before the message is swallowed.
      load_str(1, "xy^338@00003130: *00000088 <= ffffb528#");
      run(50);
      check_counters();

      // 16 stalled cycles -> abort; held src1 gets the next grant.
      load_str(0, "^242@0000");
      srcq[0].push_back(-16);
      load_str(0, "3f04#");
      load_str(1, "^338@00003130: *00000088 <= ffffb528#");
      run(90);
      check_counters();

      // 15 stalled cycles -> character on the boundary cycle wins.
      load_str(0, "^242@0000");
      srcq[0].push_back(-15);
      load_str(0, "3f04: $31 <= 12345678#");
      run(60);
      // '#' on the boundary cycle completes normally.
      load_str(2, "^ab");
      srcq[2].push_back(-15);
      load_str(2, "#");
      run(40);
      check_counters();

      // Randomized traffic from all sources.
      for (int r = 0; r < 3; r++) begin
         vprob = $urandom_range(60, 100);
         for (int s = 0; s < N; s++)
            for (int m = 0; m < 4; m++) load_random_msg(s);
         run(900);
         check_counters();
      end
      vprob = 100;

      // Leave priority pointing at src1, then reset mid-message.
      load_str(0, "^a#");
      run(10);
      load_str(0, "^242@00003f04");
      run(8);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tif.src_valid = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      owner = -1; aborting = 1'b0; stalled = 0; next_first = 0;
      m_done = 0; m_abort = 0;
      for (int i = 0; i < N; i++) begin
         srcq[i].delete();
         hold[i] = 0;
      end
      @(negedge clk);
      check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mrst_out_char", {24'b0, out_char}, 32'd0);
      check("mrst_msg_done", {16'b0, msg_done}, 32'd0);
      check("mrst_msg_abort", {16'b0, msg_abort}, 32'd0);
      check("mrst_sb_drained", sb.size(), 32'd0);
      // After reset priority restarts at src0.
      load_str(1, "^338@00003130: *00000088 <= ffffb528#");
      load_str(0, "^242@00003f04: $31 <= 12345678#");
      run(80);
      check_counters();

      check("sb_empty_end", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
